// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with occupancy counter, programmable almost-full/almost-empty
// thresholds, registered read data with valid strobe, and sticky error flags.
module fifo_umbrales #(
  parameter int data_width    = 10,
  parameter int address_width = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_enable,
  input  logic                     rd_enable,
  input  logic [data_width-1:0]    FIFO_data_in,
  input  logic [address_width:0]   umbral_alto,
  input  logic [address_width:0]   umbral_bajo,
  output logic [data_width-1:0]    FIFO_data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [address_width:0]   fifo_count,
  output logic                     error_overflow,
  output logic                     error_underflow
);

  localparam int DEPTH = 2 ** address_width;
  localparam logic [address_width:0] C_DEPTH = (address_width + 1)'(DEPTH);

  logic [data_width-1:0]    r_mem [DEPTH];
  logic [address_width-1:0] r_wr_ptr;
  logic [address_width-1:0] r_rd_ptr;
  logic [address_width:0]   r_count;
  logic [data_width-1:0]    r_data_out;
  logic                     r_data_valid;
  logic                     r_err_ovf;
  logic                     r_err_unf;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = rd_enable & ~w_empty;
  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign w_wr_ok = wr_enable & (~w_full | w_rd_ok);

  // Storage is not reset; writes coinciding with an asserted reset are dropped.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !reset) begin
      r_mem[r_wr_ptr] <= FIFO_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_unf    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + address_width'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + address_width'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_data_valid <= w_rd_ok;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (address_width + 1)'(1);
        2'b01:   r_count <= r_count - (address_width + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (wr_enable && w_full && !w_rd_ok) begin
        r_err_ovf <= 1'b1;
      end
      if (rd_enable && w_empty) begin
        r_err_unf <= 1'b1;
      end
    end
  end

  assign FIFO_data_out   = r_data_out;
  assign data_valid      = r_data_valid;
  assign full            = w_full;
  assign empty           = w_empty;
  assign almost_full     = (r_count >= umbral_alto);
  assign almost_empty    = (r_count <= umbral_bajo);
  assign fifo_count      = r_count;
  assign error_overflow  = r_err_ovf;
  assign error_underflow = r_err_unf;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed self-checking bench for fifo_umbrales (DEPTH=4, thresholds 3/1).
module tb_fifo_umbrales;

  logic       clk;
  logic       reset;
  logic       wr_enable;
  logic       rd_enable;
  logic [9:0] FIFO_data_in;
  logic [2:0] umbral_alto;
  logic [2:0] umbral_bajo;
  logic [9:0] FIFO_data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] fifo_count;
  logic       error_overflow;
  logic       error_underflow;

  int total;
  int bad;

  fifo_umbrales #(
    .data_width    (10),
    .address_width (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_enable       (wr_enable),
    .rd_enable       (rd_enable),
    .FIFO_data_in    (FIFO_data_in),
    .umbral_alto     (umbral_alto),
    .umbral_bajo     (umbral_bajo),
    .FIFO_data_out   (FIFO_data_out),
    .data_valid      (data_valid),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .fifo_count      (fifo_count),
    .error_overflow  (error_overflow),
    .error_underflow (error_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    // build some state first: two words stored, one read out
    wr_enable = 1'b1; FIFO_data_in = 10'h0AA; step();
    FIFO_data_in = 10'h0BB; step();
    wr_enable = 1'b0; rd_enable = 1'b1; step();
    rd_enable = 1'b0;
    total++;
    if (data_valid !== 1'b1 || FIFO_data_out !== 10'h0AA) begin
      bad++;
      $display("FAIL pre_reset_read: valid=%b data=%h required valid=1 data=0aa", data_valid, FIFO_data_out);
    end
    wr_enable = 1'b1; FIFO_data_in = 10'h0CC;
    #2 reset = 1'b1;
    #1;
    total++;
    if (fifo_count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || data_valid !== 1'b0 || FIFO_data_out !== 10'h000 ||
        error_overflow !== 1'b0 || error_underflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_immediate: count=%0d empty=%b full=%b ae=%b af=%b valid=%b data=%h ovf=%b unf=%b required 0 1 0 1 0 0 000 0 0",
               fifo_count, empty, full, almost_empty, almost_full, data_valid, FIFO_data_out,
               error_overflow, error_underflow);
    end
    step();
    reset = 1'b0;
    wr_enable = 1'b0;
    step();
    total++;
    if (fifo_count !== 3'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_discard_write: count=%0d empty=%b required count=0 empty=1", fifo_count, empty);
    end
  endtask

  task automatic test_fill_drain();
    for (int unsigned i = 0; i < 4; i++) begin
      wr_enable = 1'b1; FIFO_data_in = 10'(i + 1); step();
      total++;
      if (fifo_count !== 3'(i + 1) || almost_full !== (i + 1 >= 3) || full !== (i == 3) || empty !== 1'b0) begin
        bad++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b required count=%0d af=%b full=%b empty=0",
                 i, fifo_count, almost_full, full, empty, i + 1, (i + 1 >= 3), (i == 3));
      end
    end
    wr_enable = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      rd_enable = 1'b1; step();
      total++;
      if (data_valid !== 1'b1 || FIFO_data_out !== 10'(i + 1) || fifo_count !== 3'(3 - i)) begin
        bad++;
        $display("FAIL drain_%0d: valid=%b data=%h count=%0d required valid=1 data=%h count=%0d",
                 i, data_valid, FIFO_data_out, fifo_count, 10'(i + 1), 3 - i);
      end
    end
    rd_enable = 1'b0; step();
    total++;
    if (empty !== 1'b1 || data_valid !== 1'b0 || FIFO_data_out !== 10'h004 || error_underflow !== 1'b0) begin
      bad++;
      $display("FAIL drain_end: empty=%b valid=%b data=%h unf=%b required empty=1 valid=0 data=004 unf=0",
               empty, data_valid, FIFO_data_out, error_underflow);
    end
  endtask

  task automatic test_overflow();
    for (int unsigned i = 0; i < 4; i++) begin
      wr_enable = 1'b1; FIFO_data_in = 10'(16 + i); step();
    end
    FIFO_data_in = 10'h3FF; step();
    total++;
    if (error_overflow !== 1'b1 || fifo_count !== 3'd4 || full !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: ovf=%b count=%0d full=%b required ovf=1 count=4 full=1",
               error_overflow, fifo_count, full);
    end
    wr_enable = 1'b0; step();
    total++;
    if (error_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: ovf=%b required 1", error_overflow);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      rd_enable = 1'b1; step();
      total++;
      if (data_valid !== 1'b1 || FIFO_data_out !== 10'(16 + i)) begin
        bad++;
        $display("FAIL overflow_read_%0d: valid=%b data=%h required valid=1 data=%h",
                 i, data_valid, FIFO_data_out, 10'(16 + i));
      end
    end
    rd_enable = 1'b0; step();
    total++;
    if (empty !== 1'b1 || error_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_end: empty=%b ovf=%b required empty=1 ovf=1", empty, error_overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      wr_enable = 1'b1; FIFO_data_in = 10'(32 + i); step();
    end
    rd_enable = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      FIFO_data_in = 10'(36 + i); step();
      total++;
      if (data_valid !== 1'b1 || FIFO_data_out !== 10'(32 + i) || fifo_count !== 3'd4 ||
          full !== 1'b1 || error_overflow !== 1'b0) begin
        bad++;
        $display("FAIL b2b_%0d: valid=%b data=%h count=%0d full=%b ovf=%b required valid=1 data=%h count=4 full=1 ovf=0",
                 i, data_valid, FIFO_data_out, fifo_count, full, error_overflow, 10'(32 + i));
      end
    end
    wr_enable = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      total++;
      if (data_valid !== 1'b1 || FIFO_data_out !== 10'(38 + i)) begin
        bad++;
        $display("FAIL b2b_drain_%0d: valid=%b data=%h required valid=1 data=%h",
                 i, data_valid, FIFO_data_out, 10'(38 + i));
      end
    end
    rd_enable = 1'b0; step();
    total++;
    if (empty !== 1'b1 || error_overflow !== 1'b0 || error_underflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: empty=%b ovf=%b unf=%b required empty=1 ovf=0 unf=0",
               empty, error_overflow, error_underflow);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    rd_enable = 1'b1; step();
    total++;
    if (error_underflow !== 1'b1 || data_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL underflow_set: unf=%b valid=%b count=%0d required unf=1 valid=0 count=0",
               error_underflow, data_valid, fifo_count);
    end
    wr_enable = 1'b1; FIFO_data_in = 10'h155; step();
    total++;
    if (fifo_count !== 3'd1 || data_valid !== 1'b0 || error_overflow !== 1'b0) begin
      bad++;
      $display("FAIL empty_rw: count=%0d valid=%b ovf=%b required count=1 valid=0 ovf=0",
               fifo_count, data_valid, error_overflow);
    end
    wr_enable = 1'b0; step();
    total++;
    if (data_valid !== 1'b1 || FIFO_data_out !== 10'h155 || fifo_count !== 3'd0 || error_underflow !== 1'b1) begin
      bad++;
      $display("FAIL empty_rw_read: valid=%b data=%h count=%0d unf=%b required valid=1 data=155 count=0 unf=1",
               data_valid, FIFO_data_out, fifo_count, error_underflow);
    end
    rd_enable = 1'b0; step();
  endtask

  task automatic test_thresholds();
    do_reset();
    for (int unsigned c = 0; c <= 4; c++) begin
      for (int unsigned t = 0; t <= 4; t++) begin
        umbral_alto = 3'(t);
        umbral_bajo = 3'(t);
        #1;
        total++;
        if (almost_full !== (c >= t) || almost_empty !== (c <= t) || fifo_count !== 3'(c)) begin
          bad++;
          $display("FAIL thresh_c%0d_t%0d: af=%b ae=%b count=%0d required af=%b ae=%b count=%0d",
                   c, t, almost_full, almost_empty, fifo_count, (c >= t), (c <= t), c);
        end
      end
      // mixed thresholds: alto=4 with bajo=0 probes both extremes at once
      umbral_alto = 3'd4; umbral_bajo = 3'd0;
      #1;
      total++;
      if (almost_full !== (c == 4) || almost_empty !== (c == 0)) begin
        bad++;
        $display("FAIL thresh_mix_c%0d: af=%b ae=%b required af=%b ae=%b",
                 c, almost_full, almost_empty, (c == 4), (c == 0));
      end
      if (c < 4) begin
        wr_enable = 1'b1; FIFO_data_in = 10'(c); step();
        wr_enable = 1'b0;
      end
    end
    umbral_alto = 3'd3;
    umbral_bajo = 3'd1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    FIFO_data_in = '0;
    umbral_alto = 3'd3;
    umbral_bajo = 3'd1;
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_thresholds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
